// File: rtl/ex_mem.sv
// EX/MEM pipeline register: captures EX-stage control bits and data words for the MEM stage.
// Optional bubble insertion via the Flush input when EX_MEM_FLUSH_EN is defined.
module ex_mem (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        RegWrite,
  input  logic        IRegWrite,
  input  logic        IMemWrite,
  input  logic        IMemRead,
  input  logic        IRegStore,
  input  logic [15:0] IPCP2,
  input  logic [15:0] IALUResult,
  input  logic [15:0] I3rdArg,
  input  logic [15:0] IRd,
`ifdef EX_MEM_FLUSH_EN
  input  logic        Flush,
`endif
  output logic        ORegWrite,
  output logic        OMemWrite,
  output logic        OMemRead,
  output logic        ORegStore,
  output logic [15:0] OPCP2,
  output logic [15:0] OALUResult,
  output logic [15:0] O3rdArg,
  output logic [15:0] ORd
);

  logic        reg_write_q, reg_write_d;
  logic        mem_write_q, mem_write_d;
  logic        mem_read_q, mem_read_d;
  logic        reg_store_q, reg_store_d;
  logic [15:0] pcp2_q, pcp2_d;
  logic [15:0] alu_result_q, alu_result_d;
  logic [15:0] arg3_q, arg3_d;
  logic [15:0] rd_q, rd_d;
  logic        flush;

`ifdef EX_MEM_FLUSH_EN
  assign flush = Flush;
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    mem_read_d   = mem_read_q;
    reg_store_d  = reg_store_q;
    pcp2_d       = pcp2_q;
    alu_result_d = alu_result_q;
    arg3_d       = arg3_q;
    rd_d         = rd_q;
    if (flush) begin
      // Bubble: kill side effects but still carry the data words along.
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      reg_store_d  = 1'b0;
      pcp2_d       = IPCP2;
      alu_result_d = IALUResult;
      arg3_d       = I3rdArg;
      rd_d         = IRd;
    end else if (RegWrite) begin
      reg_write_d  = IRegWrite;
      mem_write_d  = IMemWrite;
      mem_read_d   = IMemRead;
      reg_store_d  = IRegStore;
      pcp2_d       = IPCP2;
      alu_result_d = IALUResult;
      arg3_d       = I3rdArg;
      rd_d         = IRd;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      reg_store_q  <= 1'b0;
      pcp2_q       <= 16'h0000;
      alu_result_q <= 16'h0000;
      arg3_q       <= 16'h0000;
      rd_q         <= 16'h0000;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
      reg_store_q  <= reg_store_d;
      pcp2_q       <= pcp2_d;
      alu_result_q <= alu_result_d;
      arg3_q       <= arg3_d;
      rd_q         <= rd_d;
    end
  end

  assign ORegWrite  = reg_write_q;
  assign OMemWrite  = mem_write_q;
  assign OMemRead   = mem_read_q;
  assign ORegStore  = reg_store_q;
  assign OPCP2      = pcp2_q;
  assign OALUResult = alu_result_q;
  assign O3rdArg    = arg3_q;
  assign ORd        = rd_q;

endmodule

// File: tb/tb_ex_mem.sv
// Scoreboard bench for ex_mem: directed sequences then random traffic against a rule-based model.
// Builds with or without EX_MEM_FLUSH_EN.
module tb_ex_mem;

  logic        clk = 1'b0;
  logic        rst, rw, fl;
  logic        i_rw, i_mw, i_mr, i_rs;
  logic [15:0] i_pc, i_alu, i_a3, i_rd;
  logic        o_rw, o_mw, o_mr, o_rs;
  logic [15:0] o_pc, o_alu, o_a3, o_rd;

  // Packed view: {RegWrite, MemWrite, MemRead, RegStore, PCP2, ALUResult, 3rdArg, Rd}
  logic [67:0] model;
  logic [67:0] exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  ex_mem dut (
    .CLK        (clk),
    .Reset      (rst),
    .RegWrite   (rw),
    .IRegWrite  (i_rw),
    .IMemWrite  (i_mw),
    .IMemRead   (i_mr),
    .IRegStore  (i_rs),
    .IPCP2      (i_pc),
    .IALUResult (i_alu),
    .I3rdArg    (i_a3),
    .IRd        (i_rd),
`ifdef EX_MEM_FLUSH_EN
    .Flush      (fl),
`endif
    .ORegWrite  (o_rw),
    .OMemWrite  (o_mw),
    .OMemRead   (o_mr),
    .ORegStore  (o_rs),
    .OPCP2      (o_pc),
    .OALUResult (o_alu),
    .O3rdArg    (o_a3),
    .ORd        (o_rd)
  );

  // Monitor: outputs are valid for the whole cycle after each edge; compare at the falling edge.
  always @(negedge clk) begin
    logic [67:0] got, want;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {o_rw, o_mw, o_mr, o_rs, o_pc, o_alu, o_a3, o_rd};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL outputs vec%0d: got ctl=%b pc=%h alu=%h a3=%h rd=%h, want ctl=%b pc=%h alu=%h a3=%h rd=%h",
                 vectors, got[67:64], got[63:48], got[47:32], got[31:16], got[15:0],
                 want[67:64], want[63:48], want[47:32], want[31:16], want[15:0]);
      end
    end
  end

  // Drive one cycle of stimulus and queue the state the register must hold after the next edge.
  task automatic step(input logic r, input logic w, input logic f, input logic [3:0] ctl,
                      input logic [15:0] pc, input logic [15:0] alu, input logic [15:0] a3,
                      input logic [15:0] rd);
    logic eff_flush;
    @(negedge clk);
    #1;
    rst = r; rw = w; fl = f;
    {i_rw, i_mw, i_mr, i_rs} = ctl;
    i_pc = pc; i_alu = alu; i_a3 = a3; i_rd = rd;
`ifdef EX_MEM_FLUSH_EN
    eff_flush = f;
`else
    eff_flush = 1'b0;
`endif
    if (r)              model = '0;
    else if (eff_flush) model = {4'b0000, pc, alu, a3, rd};
    else if (w)         model = {ctl, pc, alu, a3, rd};
    exp_q.push_back(model);
  endtask

  initial begin
    model = 'x;
    rst = 1'b0; rw = 1'b0; fl = 1'b0;
    {i_rw, i_mw, i_mr, i_rs} = 4'b0;
    i_pc = '0; i_alu = '0; i_a3 = '0; i_rd = '0;

    // Reset with RegWrite=1, then plain load of the same inputs.
    step(1, 1, 0, 4'b0000, 16'h0000, 16'h1234, 16'h5678, 16'h9ABC);
    step(0, 1, 0, 4'b0000, 16'h0000, 16'h1234, 16'h5678, 16'h9ABC);
    // Stall: capture MemRead=1/1234, hold through three edges with new inputs, then reload.
    step(0, 1, 0, 4'b0010, 16'h0002, 16'h1234, 16'h0000, 16'h0003);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 4'b0000, 16'h0004, 16'hFFFF, 16'h1111, 16'h0005);
    step(0, 1, 0, 4'b0000, 16'h0004, 16'hFFFF, 16'h1111, 16'h0005);
    // Reset priority over RegWrite.
    step(0, 1, 0, 4'b1111, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
    step(1, 1, 0, 4'b1111, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0001);
    // Control pass-through, including MemRead and MemWrite together.
    step(0, 1, 0, 4'b1101, 16'h0010, 16'h0020, 16'h0030, 16'h0040);
    step(0, 1, 0, 4'b0110, 16'h0010, 16'h0020, 16'h0030, 16'h0040);
    // Flush with RegWrite=1 and with RegWrite=0 (ignored when the feature is absent).
    step(0, 1, 1, 4'b1100, 16'h0000, 16'h4321, 16'h0000, 16'h0000);
    step(0, 1, 0, 4'b1111, 16'h1000, 16'h2000, 16'h3000, 16'h4000);
    step(0, 0, 1, 4'b1010, 16'h5555, 16'h6666, 16'h7777, 16'h8888);
    // Reset and Flush together: Reset wins.
    step(1, 0, 1, 4'b1111, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) < 5), ($urandom_range(99) < 70), ($urandom_range(99) < 12),
           4'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end

    // Drain: every queued expectation must have been consumed by the monitor.
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
